// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared opcodes, field map and bubble word
// for the DEC/EX/ME/WB hazard tracker.
package pipe_hazard_tracker_pkg;

  localparam logic [3:0] ALUR   = 4'hC;
  localparam logic [3:0] ALUI   = 4'hD;
  localparam logic [3:0] CMPR   = 4'hE;
  localparam logic [3:0] CMPI   = 4'hF;
  localparam logic [3:0] LWOP   = 4'h7;
  localparam logic [3:0] SWOP   = 4'h6;
  localparam logic [3:0] BRANCH = 4'h2;
  localparam logic [3:0] JAL    = 4'h3;

  localparam logic [3:0] F = 4'h3;

  localparam logic [31:0] BUBBLE =
    {BRANCH, F, 24'h0};

  localparam int OP_LSB = 28;
  localparam int FN_LSB = 24;
  localparam int RA_LSB = 20;
  localparam int RB_LSB = 16;
  localparam int RC_LSB = 12;

  function automatic logic [3:0] fld(
    input logic [31:0] w,
    input int          lsb
  );
    return w[lsb+:4];
  endfunction

endpackage

// File: rtl/pipe_hazard_tracker_reg_use_decode.sv
// Register usage decoder: which fields an op
// writes and reads.
module reg_use_decode
  import pipe_hazard_tracker_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] iword,
  output logic        has_dst,
  output logic [3:0]  dst,
  output logic        use1,
  output logic [3:0]  src1,
  output logic        use2,
  output logic [3:0]  src2
);

  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [19:0] unused_bits;

  assign ra = fld(iword, RA_LSB);
  assign rb = fld(iword, RB_LSB);
  assign rc = fld(iword, RC_LSB);
  assign unused_bits =
    {iword[31:24], iword[11:0]};

  // Map each op class to its dst/src fields
  always_comb begin
    has_dst = 1'b0;
    dst     = ra;
    use1    = 1'b0;
    src1    = rb;
    use2    = 1'b0;
    src2    = rc;
    unique case (1'b1)
      (op == ALUR),
      (op == CMPR): begin
        has_dst = 1'b1;
        use1    = 1'b1;
        use2    = 1'b1;
      end
      (op == ALUI),
      (op == CMPI),
      (op == LWOP),
      (op == JAL): begin
        has_dst = 1'b1;
        use1    = 1'b1;
      end
      (op == SWOP),
      (op == BRANCH): begin
        use1 = 1'b1;
        src1 = ra;
        use2 = 1'b1;
        src2 = rb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Stage-word pipeline with RAW stall, taken-
// branch flush and saturating event counters.
module pipe_hazard_tracker
  import pipe_hazard_tracker_pkg::*;
#(
  parameter int IW    = 32,
  parameter int CNT_W = 16,
  parameter logic [IW-1:0] BUBBLE =
    pipe_hazard_tracker_pkg::BUBBLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    if_iword,
  input  logic             br_taken,
  output logic [3:0]       IF_op,
  output logic [3:0]       IF_func,
  output logic [3:0]       DEC_op,
  output logic [3:0]       DEC_func,
  output logic [3:0]       EX_op,
  output logic [3:0]       EX_func,
  output logic [3:0]       ME_op,
  output logic [3:0]       ME_func,
  output logic [3:0]       WB_op,
  output logic [3:0]       WB_func,
  output logic [IW-1:0]    dec_iword,
  output logic [IW-1:0]    ex_iword,
  output logic [IW-1:0]    me_iword,
  output logic [IW-1:0]    wb_iword,
  output logic             stall,
  output logic             flush,
  output logic             pc_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  assign IF_op    = if_iword[31:28];
  assign IF_func  = if_iword[27:24];
  assign DEC_op   = dec_iword[31:28];
  assign DEC_func = dec_iword[27:24];
  assign EX_op    = ex_iword[31:28];
  assign EX_func  = ex_iword[27:24];
  assign ME_op    = me_iword[31:28];
  assign ME_func  = me_iword[27:24];
  assign WB_op    = wb_iword[31:28];
  assign WB_func  = wb_iword[27:24];

  logic       d_unused_dst;
  logic [3:0] d_unused_dn;
  logic       d_u1;
  logic [3:0] d_s1;
  logic       d_u2;
  logic [3:0] d_s2;
  logic       x_has;
  logic [3:0] x_dst;
  logic       x_unused_u1;
  logic [3:0] x_unused_s1;
  logic       x_unused_u2;
  logic [3:0] x_unused_s2;
  logic       m_has;
  logic [3:0] m_dst;
  logic       m_unused_u1;
  logic [3:0] m_unused_s1;
  logic       m_unused_u2;
  logic [3:0] m_unused_s2;

  reg_use_decode u_dec (
    .op      (DEC_op),
    .iword   (dec_iword[31:0]),
    .has_dst (d_unused_dst),
    .dst     (d_unused_dn),
    .use1    (d_u1),
    .src1    (d_s1),
    .use2    (d_u2),
    .src2    (d_s2)
  );

  reg_use_decode u_ex (
    .op      (EX_op),
    .iword   (ex_iword[31:0]),
    .has_dst (x_has),
    .dst     (x_dst),
    .use1    (x_unused_u1),
    .src1    (x_unused_s1),
    .use2    (x_unused_u2),
    .src2    (x_unused_s2)
  );

  reg_use_decode u_me (
    .op      (ME_op),
    .iword   (me_iword[31:0]),
    .has_dst (m_has),
    .dst     (m_dst),
    .use1    (m_unused_u1),
    .src1    (m_unused_s1),
    .use2    (m_unused_u2),
    .src2    (m_unused_s2)
  );

  logic hit1;
  logic hit2;
  logic hazard;

  // RAW check of DEC sources against EX/ME
  always_comb begin
    hit1 = d_u1 &&
      ((x_has && d_s1 == x_dst) ||
       (m_has && d_s1 == m_dst));
    hit2 = d_u2 &&
      ((x_has && d_s2 == x_dst) ||
       (m_has && d_s2 == m_dst));
    hazard = hit1 || hit2;
    flush  = br_taken &&
      (EX_op == BRANCH || EX_op == JAL);
    stall  = hazard && !flush;
    pc_we  = !stall;
  end

  // Stage registers: flush > stall > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_iword <= BUBBLE;
      ex_iword  <= BUBBLE;
      me_iword  <= BUBBLE;
      wb_iword  <= BUBBLE;
    end else begin
      wb_iword <= me_iword;
      me_iword <= ex_iword;
      if (flush) begin
        dec_iword <= BUBBLE;
        ex_iword  <= BUBBLE;
      end else if (stall) begin
        ex_iword  <= BUBBLE;
      end else begin
        dec_iword <= if_iword;
        ex_iword  <= dec_iword;
      end
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
